// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between the CPU control FSM and a DMA/debug loader port.
// CPU has fixed priority; a starvation counter forces a DMA grant after MAX_WAIT waiting cycles.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner
);

    localparam int unsigned LAT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t             state;
    logic               lat_we;
    logic [LAT_W-1:0]   lat_cnt;
    logic [WAIT_W-1:0]  wait_cnt;

    logic               any_req;
    logic               grant_dma;
    logic               starved;
    logic               dma_served;

    // Arbitration is only acted upon in IDLE; DMA wins when alone or when starved.
    assign starved    = (wait_cnt == WAIT_W'(MAX_WAIT));
    assign any_req    = cpu_req | dma_req;
    assign grant_dma  = dma_req & (~cpu_req | starved);
    assign dma_served = (state != S_IDLE) & owner;

    assign cpu_stall  = cpu_req & ~cpu_ack;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= S_IDLE;
            lat_we    <= 1'b0;
            lat_cnt   <= '0;
            wait_cnt  <= '0;
            owner     <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            cpu_ack   <= 1'b0;
            dma_ack   <= 1'b0;
            cpu_rdata <= '0;
            dma_rdata <= '0;
        end else begin
            // Strobes and acks are single-cycle pulses unless re-asserted below.
            mem_re  <= 1'b0;
            mem_we  <= 1'b0;
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        owner <= grant_dma;
                        if (grant_dma) begin
                            lat_we    <= dma_we;
                            mem_addr  <= dma_addr;
                            mem_wdata <= dma_wdata;
                            mem_we    <= dma_we;
                            mem_re    <= ~dma_we;
                        end else begin
                            lat_we    <= cpu_we;
                            mem_addr  <= cpu_addr;
                            mem_wdata <= cpu_wdata;
                            mem_we    <= cpu_we;
                            mem_re    <= ~cpu_we;
                        end
                        state <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    lat_cnt <= '0;
                    if (lat_we) begin
                        cpu_ack <= ~owner;
                        dma_ack <= owner;
                        state   <= S_ACK;
                    end else begin
                        state   <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    // Read data is valid in the last WAIT cycle; capture into the owner's register only.
                    if (lat_cnt == LAT_W'(RD_LAT - 1)) begin
                        if (owner) begin
                            dma_rdata <= mem_rdata;
                            dma_ack   <= 1'b1;
                        end else begin
                            cpu_rdata <= mem_rdata;
                            cpu_ack   <= 1'b1;
                        end
                        state <= S_ACK;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end

                S_ACK: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase

            // Starvation counter: counts DMA waiting cycles, saturating at MAX_WAIT.
            if (!dma_req) begin
                wait_cnt <= '0;
            end else if ((state == S_IDLE) && grant_dma) begin
                wait_cnt <= '0;
            end else if (dma_served) begin
                wait_cnt <= wait_cnt;
            end else if (!starved) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
        end
    end

endmodule
